apb_mem_slave: RTL and testbench

- Parametrised APB4 completer backed by a word-addressed register memory. Successor to the team's fixed 32x32 APB slave.
- Adds configurable data/address width, memory depth and wait-state count. Also adds byte strobes (PSTRB), error response (PSLVERR) and fully registered PREADY/PRDATA timing.
- Sits behind the APB bridge as a generic peripheral and as a bring-up target for the UVM APB agent.

---
 rtl/apb_mem_slave_if.sv | 25 ++
 rtl/apb_mem_slave.sv | 120 ++++++++++++
 tb/tb_apb_mem_slave.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_mem_slave_if.sv
// APB4 completer bus bundle: requester-driven controls plus completer responses.
interface apb_mem_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_WIDTH-1:0]     PADDR;
    logic [DATA_WIDTH-1:0]     PWDATA;
    logic [DATA_WIDTH/8-1:0]   PSTRB;
    logic                      PREADY;
    logic [DATA_WIDTH-1:0]     PRDATA;
    logic                      PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_mem_slave.sv
// Parametrised APB4 completer over a word-addressed register memory with
// byte strobes, range error response and programmable wait states.
module apb_mem_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 32,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input logic             PCLK,
    input logic             PRESET,
    apb_mem_slave_if.slave  bus
);
    localparam int unsigned BYTES    = DATA_WIDTH / 8;
    localparam int unsigned LSB      = $clog2(BYTES);
    localparam int unsigned MEM_AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CNT_W    = 4;
    localparam bit          HAS_WAIT = (WAIT_CYCLES != 0);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS} state_t;

    state_t                 state_q, state_n;
    logic [CNT_W-1:0]       cnt_q, cnt_n;
    logic                   write_q, write_n;
    logic                   err_q, err_n;
    logic [MEM_AW-1:0]      idx_q, idx_n;
    logic [DATA_WIDTH-1:0]  prdata_q, prdata_n;
    logic                   pready_q, pready_n;
    logic                   pslverr_q, pslverr_n;
    logic                   mem_we;

    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    // Full word index including the upper address bits, so any stray high bit
    // lands out of range instead of aliasing into the array.
    logic                   range_err;
    logic [MEM_AW-1:0]      setup_idx;
    assign range_err = 64'(bus.PADDR >> LSB) >= 64'(MEM_DEPTH);
    assign setup_idx = MEM_AW'(bus.PADDR >> LSB);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            write_q   <= write_n;
            err_q     <= err_n;
            idx_q     <= idx_n;
            prdata_q  <= prdata_n;
            pready_q  <= pready_n;
            pslverr_q <= pslverr_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        write_n  = write_q;
        err_n    = err_q;
        idx_n    = idx_q;
        prdata_n = prdata_q;
        mem_we   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    write_n = bus.PWRITE;
                    idx_n   = setup_idx;
                    err_n   = range_err;
                    if (!bus.PWRITE) begin
                        prdata_n = range_err ? '0 : mem[setup_idx];
                    end
                    if (HAS_WAIT) begin
                        state_n = ST_WAIT;
                        cnt_n   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_n = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (!(bus.PSEL && bus.PENABLE)) begin
                    state_n = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_n = ST_ACCESS;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                state_n = ST_IDLE;
                mem_we  = bus.PSEL && bus.PENABLE && write_q && !err_q && !PRESET;
            end
            default: state_n = ST_IDLE;
        endcase
        // Response flags are registered off the next state, never the live bus.
        pready_n  = (state_n == ST_ACCESS);
        pslverr_n = (state_n == ST_ACCESS) && err_n;
    end

    always_ff @(posedge PCLK) begin
        if (mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (bus.PSTRB[i]) begin
                    mem[idx_q][8*i +: 8] <= bus.PWDATA[8*i +: 8];
                end
            end
        end
    end

    assign bus.PREADY  = pready_q;
    assign bus.PSLVERR = pslverr_q;
    assign bus.PRDATA  = prdata_q;
endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: three instances (0, 2 and 3 wait states)
// share one set of bus drivers; PSEL is steered to the instance under test.
module tb_apb_mem_slave;
    logic        PCLK;
    logic [2:0]  rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    int          cur;
    logic        rdy, slverr;
    logic [31:0] prdata;
    int          n_tests = 0;
    int          n_fail  = 0;

    apb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    apb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();
    apb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

    assign bus0.PSEL = psel && (cur == 0);
    assign bus2.PSEL = psel && (cur == 1);
    assign bus3.PSEL = psel && (cur == 2);
    assign bus0.PENABLE = penable; assign bus2.PENABLE = penable; assign bus3.PENABLE = penable;
    assign bus0.PWRITE  = pwrite;  assign bus2.PWRITE  = pwrite;  assign bus3.PWRITE  = pwrite;
    assign bus0.PADDR   = paddr;   assign bus2.PADDR   = paddr;   assign bus3.PADDR   = paddr;
    assign bus0.PWDATA  = pwdata;  assign bus2.PWDATA  = pwdata;  assign bus3.PWDATA  = pwdata;
    assign bus0.PSTRB   = pstrb;   assign bus2.PSTRB   = pstrb;   assign bus3.PSTRB   = pstrb;

    apb_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(32), .WAIT_CYCLES(0))
        dut0 (.PCLK(PCLK), .PRESET(rst[0]), .bus(bus0.slave));
    apb_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(32), .WAIT_CYCLES(2))
        dut2 (.PCLK(PCLK), .PRESET(rst[1]), .bus(bus2.slave));
    apb_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(32), .WAIT_CYCLES(3))
        dut3 (.PCLK(PCLK), .PRESET(rst[2]), .bus(bus3.slave));

    always_comb begin
        case (cur)
            0:       begin rdy = bus0.PREADY; slverr = bus0.PSLVERR; prdata = bus0.PRDATA; end
            1:       begin rdy = bus2.PREADY; slverr = bus2.PSLVERR; prdata = bus2.PRDATA; end
            default: begin rdy = bus3.PREADY; slverr = bus3.PSLVERR; prdata = bus3.PRDATA; end
        endcase
    end

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle(input int n);
        psel = 1'b0; penable = 1'b0;
        repeat (n) tick();
    endtask

    // One transfer; returns the access-phase response, the number of wait
    // cycles seen, any PSLVERR during waits and PREADY after completion.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic [31:0] rd, output logic er,
                        output int waits, output logic werr, output logic rdy_after);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        tick();
        penable = 1'b1;
        waits = 0; werr = 1'b0;
        while (!rdy && waits < 20) begin
            werr = werr | slverr;
            tick();
            waits++;
        end
        rd = prdata; er = slverr;
        tick();
        rdy_after = rdy;
    endtask

    task automatic test_reset();
        rst = 3'b111;
        repeat (2) tick();
        rst = 3'b000;
        for (int k = 0; k < 3; k++) begin
            cur = k; #1;
            n_tests++;
            if (rdy !== 1'b0 || slverr !== 1'b0 || prdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset[%0d]: pready=%b pslverr=%b prdata=%h, need 0/0/0", k, rdy, slverr, prdata);
            end
        end
        cur = 0;
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er, we, ra; int w;
        cur = 0;
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, w, we, ra);
        n_tests++;
        if (w !== 0 || er !== 1'b0 || ra !== 1'b0) begin
            n_fail++; $display("FAIL basic_wr: waits=%0d err=%b rdy_after=%b, need 0/0/0", w, er, ra);
        end
        idle(1);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, w, we, ra);
        n_tests++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || w !== 0 || ra !== 1'b0) begin
            n_fail++; $display("FAIL basic_rd: rd=%h err=%b waits=%0d rdy_after=%b, need deadbeef/0/0/0", rd, er, w, ra);
        end
        idle(1);
    endtask

    task automatic test_strobes();
        logic [31:0] rd; logic er, we, ra; int w;
        cur = 0;
        xfer(1'b1, 32'h0, 32'h11223344, 4'hF, rd, er, w, we, ra);
        idle(1);
        xfer(1'b1, 32'h0, 32'hAABBCCDD, 4'h5, rd, er, w, we, ra);
        idle(1);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, er, w, we, ra);
        n_tests++;
        if (rd !== 32'h11BB33DD) begin
            n_fail++; $display("FAIL strobe_0x5: rd=%h need 11bb33dd", rd);
        end
        idle(1);
        xfer(1'b1, 32'h0, 32'hEE000000, 4'h8, rd, er, w, we, ra);
        idle(1);
        xfer(1'b0, 32'h3, 32'h0, 4'h0, rd, er, w, we, ra);
        n_tests++;
        if (rd !== 32'hEEBB33DD) begin
            n_fail++; $display("FAIL strobe_0x8_unaligned: rd=%h need eebb33dd", rd);
        end
        idle(1);
        xfer(1'b1, 32'h0, 32'h11BB33DD, 4'hF, rd, er, w, we, ra);
        idle(1);
    endtask

    task automatic test_error();
        logic [31:0] rd; logic er, we, ra; int w;
        cur = 0;
        xfer(1'b1, 32'h7C, 32'hCAFEF00D, 4'hF, rd, er, w, we, ra);
        idle(1);
        xfer(1'b1, 32'h80, 32'hFFFFFFFF, 4'hF, rd, er, w, we, ra);
        n_tests++;
        if (er !== 1'b1 || w !== 0) begin
            n_fail++; $display("FAIL err_wr: err=%b waits=%0d, need 1/0", er, w);
        end
        n_tests++;
        if (ra !== 1'b0 || slverr !== 1'b0) begin
            n_fail++; $display("FAIL err_clear: pready=%b pslverr=%b after completion, need 0/0", ra, slverr);
        end
        idle(1);
        xfer(1'b0, 32'h80, 32'h0, 4'h0, rd, er, w, we, ra);
        n_tests++;
        if (er !== 1'b1 || rd !== 32'h0 || w !== 0) begin
            n_fail++; $display("FAIL err_rd: err=%b rd=%h waits=%0d, need 1/0/0", er, rd, w);
        end
        idle(1);
        xfer(1'b0, 32'h80000010, 32'h0, 4'h0, rd, er, w, we, ra);
        n_tests++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_fail++; $display("FAIL err_high_bit: err=%b rd=%h, need 1/0", er, rd);
        end
        idle(1);
        xfer(1'b0, 32'h7C, 32'h0, 4'h0, rd, er, w, we, ra);
        n_tests++;
        if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL err_last_word: err=%b rd=%h, need 0/cafef00d", er, rd);
        end
        idle(1);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, er, w, we, ra);
        n_tests++;
        if (rd !== 32'h11BB33DD) begin
            n_fail++; $display("FAIL err_no_alias: mem[0]=%h need 11bb33dd", rd);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er, we, ra; int w;
        cur = 0;
        xfer(1'b1, 32'h8, 32'h5A5A1234, 4'hF, rd, er, w, we, ra);
        n_tests++;
        if (ra !== 1'b0 || w !== 0) begin
            n_fail++; $display("FAIL b2b_wr: rdy_after=%b waits=%0d, need 0/0", ra, w);
        end
        xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, er, w, we, ra);
        n_tests++;
        if (rd !== 32'h5A5A1234 || er !== 1'b0 || w !== 0 || ra !== 1'b0) begin
            n_fail++; $display("FAIL b2b_rd: rd=%h err=%b waits=%0d rdy_after=%b, need 5a5a1234/0/0/0", rd, er, w, ra);
        end
        xfer(1'b1, 32'h8, 32'h00000000, 4'hF, rd, er, w, we, ra);
        n_tests++;
        if (rd !== 32'h5A5A1234) begin
            n_fail++; $display("FAIL prdata_hold_on_write: prdata=%h need 5a5a1234", rd);
        end
        idle(1);
    endtask

    task automatic test_protocol();
        cur = 0;
        psel = 1'b1; penable = 1'b1; paddr = 32'h10; pwrite = 1'b0;
        tick();
        n_tests++;
        if (rdy !== 1'b0) begin
            n_fail++; $display("FAIL penable_in_idle_1: pready=%b need 0", rdy);
        end
        tick();
        n_tests++;
        if (rdy !== 1'b0 || prdata !== 32'h5A5A1234) begin
            n_fail++; $display("FAIL penable_in_idle_2: pready=%b prdata=%h, need 0/5a5a1234", rdy, prdata);
        end
        idle(1);
    endtask

    task automatic test_wait2();
        logic [31:0] rd; logic er, we, ra; int w;
        cur = 1;
        xfer(1'b1, 32'h4, 32'h12345678, 4'hF, rd, er, w, we, ra);
        n_tests++;
        if (w !== 2 || we !== 1'b0 || er !== 1'b0) begin
            n_fail++; $display("FAIL wait2_wr: waits=%0d werr=%b err=%b, need 2/0/0", w, we, er);
        end
        idle(1);
        xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, er, w, we, ra);
        n_tests++;
        if (w !== 2 || we !== 1'b0 || er !== 1'b0 || rd !== 32'h12345678 || ra !== 1'b0) begin
            n_fail++; $display("FAIL wait2_rd: waits=%0d werr=%b err=%b rd=%h rdy_after=%b, need 2/0/0/12345678/0",
                               w, we, er, rd, ra);
        end
        idle(1);
    endtask

    task automatic test_abort_reset();
        logic [31:0] rd; logic er, we, ra; int w;
        cur = 2;
        xfer(1'b1, 32'hC, 32'h0F0F0F0F, 4'hF, rd, er, w, we, ra);
        n_tests++;
        if (w !== 3) begin
            n_fail++; $display("FAIL wait3_wr: waits=%0d need 3", w);
        end
        idle(1);
        // Abort: drop PSEL during the second wait cycle.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0;
        tick();
        n_tests++;
        if (rdy !== 1'b0) begin
            n_fail++; $display("FAIL abort_ready: pready=%b need 0", rdy);
        end
        repeat (4) tick();
        n_tests++;
        if (rdy !== 1'b0) begin
            n_fail++; $display("FAIL abort_stays_idle: pready=%b need 0", rdy);
        end
        idle(1);
        xfer(1'b0, 32'hC, 32'h0, 4'h0, rd, er, w, we, ra);
        n_tests++;
        if (rd !== 32'h0F0F0F0F) begin
            n_fail++; $display("FAIL abort_mem: rd=%h need 0f0f0f0f", rd);
        end
        idle(1);
        // Reset in the middle of the wait states of a write.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        tick();
        penable = 1'b1;
        tick();
        rst[2] = 1'b1;
        tick();
        n_tests++;
        if (rdy !== 1'b0 || prdata !== 32'h0 || slverr !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_wait: pready=%b prdata=%h pslverr=%b, need 0/0/0", rdy, prdata, slverr);
        end
        rst[2] = 1'b0;
        idle(6);
        n_tests++;
        if (rdy !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_access: pready=%b need 0", rdy);
        end
        xfer(1'b0, 32'hC, 32'h0, 4'h0, rd, er, w, we, ra);
        n_tests++;
        if (rd !== 32'h0F0F0F0F || w !== 3) begin
            n_fail++; $display("FAIL reset_mem: rd=%h waits=%0d, need 0f0f0f0f/3", rd, w);
        end
        idle(1);
    endtask

    initial begin
        cur = 0; rst = 3'b111;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        tick();
        test_reset();
        test_basic();
        test_strobes();
        test_error();
        test_back_to_back();
        test_protocol();
        test_wait2();
        test_abort_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
